// File: rtl/sobel_pkg.sv
// Shared constants for the packed-grayscale feeder ahead of the sobel stage.
package sobel_pkg;

    // Default BT.601-style luma weights in 1/256 units (they must sum to 256).
    localparam int KR_DEF       = 77;
    localparam int KG_DEF       = 150;
    localparam int KB_DEF       = 29;

    // Four luma bytes share one output beat.
    localparam int PIX_PER_WORD = 4;

    // Half an LSB after the >>8, so the luma value is rounded rather than truncated.
    localparam int LUMA_RND     = 128;

    // Lane index within the word being packed.
    typedef logic [1:0] lane_t;

endpackage

// File: rtl/sobel_gray_pack_if.sv
// One AXI-Stream link: data, frame marker and the valid/ready handshake.
interface sobel_gray_pack_if #(
    parameter int DW = 32
);
    logic [DW-1:0] TDATA;
    logic          TLAST;
    logic          TVALID;
    logic          TREADY;

    modport master (output TDATA, output TLAST, output TVALID, input  TREADY);
    modport slave  (input  TDATA, input  TLAST, input  TVALID, output TREADY);
endinterface

// File: rtl/sobel_luma_calc.sv
// Combinational RGB to luma conversion: Y = (KR*R + KG*G + KB*B + 128) >> 8.
module sobel_luma_calc
    import sobel_pkg::*;
#(
    parameter int KR = KR_DEF,
    parameter int KG = KG_DEF,
    parameter int KB = KB_DEF,
    parameter int MW = 8
) (
    input  logic [MW-1:0] r_i,
    input  logic [MW-1:0] g_i,
    input  logic [MW-1:0] b_i,
    output logic [MW-1:0] y_o
);
    localparam int SW = 2 * MW;

    logic [SW-1:0] sum;

    // The weights sum to 256, so the worst case is 255*256+128 = 65408.
    // That fits 16 bits, so there is no overflow and no clamp is needed.
    always_comb begin
        sum = SW'(KR) * SW'(r_i) + SW'(KG) * SW'(g_i) + SW'(KB) * SW'(b_i) + SW'(LUMA_RND);
        y_o = sum[SW-1:MW];
    end

    logic unused_lsb;
    assign unused_lsb = ^sum[MW-1:0];
endmodule

// File: rtl/sobel_gray_pack.sv
// Converts one 0x00RRGGBB pixel per input beat to luma. Packs four luma bytes per
// output word, with lane 0 holding the earliest pixel. Zero-pads the last word of a
// frame and marks it with TLAST. Also keeps frame and pixel status counters.
module sobel_gray_pack
    import sobel_pkg::*;
#(
    parameter int DATAWIDTH   = 32,
    parameter int MEMORYWIDTH = 8,
    parameter int KR          = KR_DEF,
    parameter int KG          = KG_DEF,
    parameter int KB          = KB_DEF,
    parameter int CNTWIDTH    = 16
) (
    input  logic                CLK,
    input  logic                ARESET,
    sobel_gray_pack_if.slave    s_axis,
    sobel_gray_pack_if.master   m_axis,
    output logic [CNTWIDTH-1:0] FRAME_CNT,
    output logic [CNTWIDTH-1:0] PIX_CNT
);
    localparam int MW = MEMORYWIDTH;
    localparam int HW = (PIX_PER_WORD - 1) * MW;

    // Stage A: the converted pixel that is waiting to be packed.
    logic                 a_valid_q, a_valid_d;
    logic [MW-1:0]        a_luma_q,  a_luma_d;
    logic                 a_last_q,  a_last_d;

    // Pack state: the lane that the stage A item goes to, and lanes 0..2 already collected.
    lane_t                lane_q,    lane_d;
    logic [HW-1:0]        hold_q,    hold_d;

    // Output register. The output port signals are driven straight from these flops.
    logic [DATAWIDTH-1:0] m_data_q,  m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q,  m_last_d;

    logic [CNTWIDTH-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNTWIDTH-1:0]  pix_cnt_q,   pix_cnt_d;

    logic [MW-1:0]        luma_y;
    logic                 completes, a_adv, s_ready, in_hs, m_hs;
    logic [DATAWIDTH-1:0] word;

    sobel_luma_calc #(
        .KR (KR),
        .KG (KG),
        .KB (KB),
        .MW (MW)
    ) u_luma (
        .r_i (s_axis.TDATA[2*MW +: MW]),
        .g_i (s_axis.TDATA[MW   +: MW]),
        .b_i (s_axis.TDATA[0    +: MW]),
        .y_o (luma_y)
    );

    // The top byte of the pixel beat carries no colour.
    logic unused_pad;
    assign unused_pad = ^s_axis.TDATA[DATAWIDTH-1:3*MW];

    // Handshake. Only a word-completing item can stall: it must wait for the output to free up.
    // This gives a combinational path from the downstream ready to the upstream ready.
    always_comb begin
        completes = (lane_q == lane_t'(PIX_PER_WORD - 1)) | a_last_q;
        a_adv     = a_valid_q & (~completes | ~m_valid_q | m_axis.TREADY);
        s_ready   = ~ARESET & (~a_valid_q | a_adv);
        in_hs     = s_axis.TVALID & s_ready;
        m_hs      = m_valid_q & m_axis.TREADY;
    end

    // Completed word. Lanes below the current lane come from the hold register, the
    // current lane is the stage A luma, and lanes above it are zero (frame-end padding).
    always_comb begin
        word = '0;
        for (int i = 0; i < PIX_PER_WORD - 1; i++) begin
            if (lane_t'(i) < lane_q)
                word[i*MW +: MW] = hold_q[i*MW +: MW];
            else if (lane_t'(i) == lane_q)
                word[i*MW +: MW] = a_luma_q;
        end
        if (lane_q == lane_t'(PIX_PER_WORD - 1))
            word[(PIX_PER_WORD-1)*MW +: MW] = a_luma_q;
    end

    // Next state for stage A, the packer, the output register and the counters.
    always_comb begin
        a_valid_d   = a_valid_q;
        a_luma_d    = a_luma_q;
        a_last_d    = a_last_q;
        lane_d      = lane_q;
        hold_d      = hold_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        frame_cnt_d = frame_cnt_q;
        pix_cnt_d   = pix_cnt_q;

        if (in_hs) begin
            a_valid_d = 1'b1;
            a_luma_d  = luma_y;
            a_last_d  = s_axis.TLAST;
        end else if (a_adv) begin
            a_valid_d = 1'b0;
        end

        if (a_adv) begin
            if (completes) begin
                lane_d = '0;
            end else begin
                lane_d = lane_q + lane_t'(1);
                for (int i = 0; i < PIX_PER_WORD - 1; i++)
                    if (lane_t'(i) == lane_q)
                        hold_d[i*MW +: MW] = a_luma_q;
            end
        end

        // A completion that coincides with a handshake reloads directly, so no bubble is inserted.
        if (a_adv && completes) begin
            m_data_d  = word;
            m_valid_d = 1'b1;
            m_last_d  = a_last_q;
        end else if (m_hs) begin
            m_valid_d = 1'b0;
        end

        if (m_hs && m_last_q)
            frame_cnt_d = frame_cnt_q + CNTWIDTH'(1);

        if (in_hs) begin
            if (s_axis.TLAST)
                pix_cnt_d = '0;
            else if (pix_cnt_q != '1)
                pix_cnt_d = pix_cnt_q + CNTWIDTH'(1);
        end
    end

    // State registers. Reset drops everything in flight, including any partial word.
    always_ff @(posedge CLK or posedge ARESET) begin
        if (ARESET) begin
            a_valid_q   <= 1'b0;
            a_luma_q    <= '0;
            a_last_q    <= 1'b0;
            lane_q      <= '0;
            hold_q      <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_cnt_q <= '0;
            pix_cnt_q   <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_luma_q    <= a_luma_d;
            a_last_q    <= a_last_d;
            lane_q      <= lane_d;
            hold_q      <= hold_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            frame_cnt_q <= frame_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
        end
    end

    assign s_axis.TREADY = s_ready;
    assign m_axis.TDATA  = m_data_q;
    assign m_axis.TVALID = m_valid_q;
    assign m_axis.TLAST  = m_last_q;
    assign FRAME_CNT     = frame_cnt_q;
    assign PIX_CNT       = pix_cnt_q;
endmodule

// File: tb/tb_sobel_gray_pack.sv
// Directed bench for sobel_gray_pack. Expected words are hand computed. Gray pixels
// (R=G=B=v) map to luma v, which keeps the expected words for the larger streams simple.
module tb_sobel_gray_pack;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] frame_cnt, pix_cnt;

    always #5 clk = ~clk;

    sobel_gray_pack_if #(.DW(32)) s_if ();
    sobel_gray_pack_if #(.DW(32)) m_if ();

    sobel_gray_pack dut (
        .CLK       (clk),
        .ARESET    (rst),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .FRAME_CNT (frame_cnt),
        .PIX_CNT   (pix_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    // Output capture and input-side observation, sampled on the falling edge.
    logic [32:0] out_q[$];
    logic [32:0] exp_q[$];
    bit          cap_en = 1'b1;
    int          stall_cnt = 0;
    int          full_acc = 0;

    always @(negedge clk) begin
        if (cap_en && m_if.TVALID && m_if.TREADY) out_q.push_back({m_if.TLAST, m_if.TDATA});
        if (s_if.TVALID && !s_if.TREADY) stall_cnt++;
        if (s_if.TVALID && s_if.TREADY && m_if.TVALID && !m_if.TREADY) full_acc++;
    end

    function automatic logic [31:0] gpx(input logic [7:0] v);
        return {8'h00, v, v, v};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One input beat; returns 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] d, input logic l);
        bit ok;
        int w;
        ok = 1'b0;
        w  = 0;
        s_if.TDATA  = d;
        s_if.TLAST  = l;
        s_if.TVALID = 1'b1;
        do begin
            @(negedge clk);
            ok = s_if.TREADY;
            @(posedge clk);
            #1;
            w++;
        end while (!ok && w < 200);
        if (!ok) chk("send_timeout", 0, 1);
        s_if.TVALID = 1'b0;
        s_if.TLAST  = 1'b0;
    endtask

    task automatic check_out(input string tag);
        int n;
        chk({tag, "_nwords"}, out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, out_q[i], exp_q[i]);
        out_q.delete();
        exp_q.delete();
    endtask

    int          exp_frames = 0;
    bit          seen;
    logic [32:0] held;
    int          chg;

    initial begin
        rst         = 1'b1;
        s_if.TDATA  = '0;
        s_if.TLAST  = 1'b0;
        s_if.TVALID = 1'b0;
        m_if.TREADY = 1'b1;
        #12;
        chk("rst_s_tready", s_if.TREADY, 0);
        chk("rst_m_tvalid", m_if.TVALID, 0);
        chk("rst_m_tdata",  m_if.TDATA,  0);
        chk("rst_frame",    frame_cnt,   0);
        chk("rst_pix",      pix_cnt,     0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // 1: primary colours -> 0x1D954DFF
        send(32'h00FFFFFF, 0);
        send(32'h00FF0000, 0);
        send(32'h0000FF00, 0);
        send(32'h000000FF, 0);
        idle(4);
        exp_q.push_back({1'b0, 32'h1D954DFF});
        check_out("t1_word");
        chk("t1_pix", pix_cnt, 4);

        // 2: six white pixels, the second word is padded and carries TLAST
        for (int i = 0; i < 6; i++) begin
            send(32'h00FFFFFF, i == 5);
            if (i == 4) chk("t2_pix_mid", pix_cnt, 9);
        end
        idle(4);
        exp_q.push_back({1'b0, 32'hFFFFFFFF});
        exp_q.push_back({1'b1, 32'h0000FFFF});
        check_out("t2_word");
        exp_frames++;
        chk("t2_frame", frame_cnt, exp_frames);
        chk("t2_pix",   pix_cnt,   0);

        // 3: 64-pixel frame at full rate
        stall_cnt = 0;
        for (int i = 0; i < 64; i++) send(gpx(8'(i)), i == 63);
        @(posedge clk);
        #1;
        chk("t3_end_valid", m_if.TVALID, 1);
        chk("t3_end_last",  m_if.TLAST,  1);
        chk("t3_end_data",  m_if.TDATA,  32'h3F3E3D3C);
        idle(5);
        chk("t3_stalls", stall_cnt, 0);
        for (int w = 0; w < 16; w++)
            exp_q.push_back({w == 15, 8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        check_out("t3_word");
        exp_frames++;
        chk("t3_frame", frame_cnt, exp_frames);

        // 4: downstream stalls for 20 cycles mid-stream
        seen = 1'b0;
        held = '0;
        chg  = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(gpx(8'(8'h40 + i)), i == 15);
            end
            begin
                idle(6);
                full_acc    = 0;
                m_if.TREADY = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (m_if.TVALID) begin
                        if (!seen) begin
                            seen = 1'b1;
                            held = {m_if.TLAST, m_if.TDATA};
                        end else if ({m_if.TLAST, m_if.TDATA} != held) begin
                            chg++;
                        end
                    end
                end
                @(posedge clk);
                #1 m_if.TREADY = 1'b1;
            end
        join
        idle(10);
        chk("t4_seen_valid", seen, 1);
        chk("t4_data_stable", chg, 0);
        chk("t4_extra_le3", full_acc <= 3, 1);
        for (int w = 0; w < 4; w++)
            exp_q.push_back({w == 3, 8'(8'h43+4*w), 8'(8'h42+4*w), 8'(8'h41+4*w), 8'(8'h40+4*w)});
        check_out("t4_word");
        exp_frames++;
        chk("t4_frame", frame_cnt, exp_frames);

        // 5: reset after two pixels of a frame
        send(gpx(8'h11), 0);
        send(gpx(8'h22), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_m_tvalid", m_if.TVALID, 0);
        chk("t5_m_tdata",  m_if.TDATA,  0);
        chk("t5_s_tready", s_if.TREADY, 0);
        chk("t5_frame",    frame_cnt,   0);
        chk("t5_pix",      pix_cnt,     0);
        exp_frames = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        for (int i = 1; i <= 4; i++) send(gpx(8'(i)), 0);
        idle(4);
        exp_q.push_back({1'b0, 32'h04030201});
        check_out("t5_word");
        chk("t5_pix_after", pix_cnt, 4);

        // 6: single-pixel frame, then run the frame counter through its wrap
        send(32'h00808080, 1);
        idle(4);
        exp_q.push_back({1'b1, 32'h00000080});
        check_out("t6_word");
        exp_frames++;
        chk("t6_frame", frame_cnt, exp_frames);
        chk("t6_pix",   pix_cnt,   0);
        cap_en = 1'b0;
        while (exp_frames < 16'hFFFF) begin
            send(32'h00808080, 1);
            exp_frames++;
        end
        idle(3);
        chk("t6_frame_max", frame_cnt, 16'hFFFF);
        send(32'h00808080, 1);
        idle(3);
        chk("t6_frame_wrap", frame_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
